// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, sequencer states and
// the opcode classifier used by both the sequencer and the decoder.
package cpu16_pkg;

    localparam int PC_W_DEFAULT = 8;

    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Opcodes 0-6 are register/immediate ALU ops; 10-14 are unassigned.
    function automatic op_class_t classify_op(input logic [3:0] op);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        if (op <= 4'd6)          cls = CLS_ALU;
        else if (op == OP_LW)    cls = CLS_LOAD;
        else if (op == OP_SW)    cls = CLS_STORE;
        else if (op == OP_JMP)   cls = CLS_JUMP;
        else if (op == OP_HALT)  cls = CLS_HALT;
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: owns PC and IR, fetches instructions and steps each
// one through decode, execute, memory and write-back with enable strobes.
module control_sequencer
    import cpu16_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      ir,
    output logic [PC_W-1:0]  pc,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state
);

    state_t    cur_state;
    state_t    next_state;
    state_t    boundary_state;
    op_class_t op_class;

    assign op_class       = classify_op(ir[3:0]);
    assign boundary_state = run ? ST_FETCH : ST_IDLE;
    assign imem_addr      = pc;
    assign halted         = (cur_state == ST_HALT);
    assign state          = cur_state;

    // Strobes depend only on the current state and the latched IR; the one
    // exception is a store, which completes on its memory ready beat.
    always_comb begin
        next_state = cur_state;
        imem_req   = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        retire     = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (run) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_class == CLS_HALT) begin
                    next_state = ST_HALT;
                end else if (op_class == CLS_ILLEGAL) begin
                    retire     = 1'b1;
                    next_state = boundary_state;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                if (op_class == CLS_JUMP) begin
                    retire     = 1'b1;
                    next_state = boundary_state;
                end else if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
                    next_state = ST_MEM;
                end else begin
                    next_state = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class == CLS_STORE);
                if (dmem_ready) begin
                    if (op_class == CLS_STORE) begin
                        retire     = 1'b1;
                        next_state = boundary_state;
                    end else begin
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                retire     = 1'b1;
                next_state = boundary_state;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // A jump in EXEC overrides the increment done when it was fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            pc          <= '0;
            ir          <= '0;
            retired_cnt <= '0;
            illegal     <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (cur_state == ST_FETCH && imem_ready) begin
                ir <= imem_rdata;
                pc <= pc + PC_W'(1);
            end
            if (cur_state == ST_EXEC && op_class == CLS_JUMP) begin
                pc <= ir[4 +: PC_W];
            end
            if (cur_state == ST_DECODE && op_class == CLS_ILLEGAL) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: acts as instruction/data memory with
// chosen wait states and compares per-instruction behaviour to a cycle-count model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_we;
    logic        retire;
    logic [15:0] retired_cnt;
    logic        halted;
    logic        illegal;
    logic [2:0]  state;

    int check_count = 0;
    int fail_count  = 0;

    logic [7:0]  m_pc      = 8'h00;
    logic [15:0] m_cnt     = 16'h0000;
    logic        m_illegal = 1'b0;

    control_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .pc          (pc),
        .alu_en      (alu_en),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .reg_we      (reg_we),
        .retire      (retire),
        .retired_cnt (retired_cnt),
        .halted      (halted),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Runs one instruction to completion, starting and ending at posedge+1.
    // abort_at >= 0 asserts reset on that data-request cycle and returns.
    task automatic apply_stimulus(input logic [15:0] instr, input int iw, input int dw,
                                  input bit drop_run, input int abort_at, input bit rand_ready);
        int cyc = 0, alu_n = 0, regwe_n = 0, regwe_at = 0, dreq_n = 0, dwe_n = 0;
        int ireq_n = 0, retire_n = 0, budget = 0;
        int exp_cyc, exp_alu, exp_regwe, exp_dreq, exp_dwe, exp_retire;
        bit done = 0, addr_checked = 0, aborted = 0;
        bit is_alu, is_lw, is_sw, is_jmp, is_halt, is_ill;
        logic [3:0] op;
        string tag;

        op      = instr[3:0];
        tag     = $sformatf("op%0d_%04h", op, instr);
        is_alu  = (op <= 4'd6);
        is_lw   = (op == 4'd7);
        is_sw   = (op == 4'd8);
        is_jmp  = (op == 4'd9);
        is_halt = (op == 4'd15);
        is_ill  = !(is_alu || is_lw || is_sw || is_jmp || is_halt);

        exp_cyc    = 1 + iw;
        exp_alu    = 0;
        exp_regwe  = 0;
        exp_dreq   = 0;
        exp_dwe    = 0;
        exp_retire = 1;
        if (is_halt) begin
            exp_cyc += 1;
            exp_retire = 0;
        end else if (is_ill) begin
            exp_cyc += 1;
        end else if (is_jmp) begin
            exp_cyc += 2;
            exp_alu = 1;
        end else if (is_alu) begin
            exp_cyc += 3;
            exp_alu = 1;
            exp_regwe = 1;
        end else if (is_lw) begin
            exp_cyc += 4 + dw;
            exp_alu = 1;
            exp_regwe = 1;
            exp_dreq = 1 + dw;
        end else begin
            exp_cyc += 3 + dw;
            exp_alu = 1;
            exp_dreq = 1 + dw;
            exp_dwe = 1 + dw;
        end

        while (!done && budget < 300) begin
            budget++;
            if (is_halt && halted) begin
                done = 1;
                break;
            end
            if (state != 3'd0) cyc++;
            if (imem_req) begin
                if (!addr_checked) begin
                    check_output({tag, "_imem_addr"}, imem_addr, m_pc);
                    addr_checked = 1;
                end
                imem_rdata = instr;
                imem_ready = (ireq_n == iw);
                ireq_n++;
            end else begin
                imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = 16'($urandom);
            end
            if (dmem_req) begin
                if (abort_at >= 0 && dreq_n == abort_at) begin
                    reset = 1'b1;
                    dmem_ready = 1'b0;
                    aborted = 1;
                    break;
                end
                dmem_ready = (dreq_n == dw);
                dreq_n++;
                if (dmem_we) dwe_n++;
                if (drop_run) run = 1'b0;
            end else begin
                dmem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (alu_en) alu_n++;
            if (reg_we) begin
                regwe_n++;
                regwe_at = cyc;
            end
            #1;
            if (retire) begin
                retire_n++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (aborted) return;

        check_output({tag, "_completed"}, done, 1);
        if (!is_halt) m_pc = m_pc + 8'd1;
        if (is_jmp)   m_pc = instr[11:4];
        if (is_ill)   m_illegal = 1'b1;
        if (exp_retire == 1) m_cnt = m_cnt + 16'd1;

        check_output({tag, "_cycles"}, cyc, exp_cyc);
        check_output({tag, "_alu_en"}, alu_n, exp_alu);
        check_output({tag, "_reg_we"}, regwe_n, exp_regwe);
        check_output({tag, "_dmem_req"}, dreq_n, exp_dreq);
        check_output({tag, "_dmem_we"}, dwe_n, exp_dwe);
        check_output({tag, "_retire"}, retire_n, exp_retire);
        check_output({tag, "_pc"}, is_halt ? m_pc + 8'd1 : m_pc, pc);
        check_output({tag, "_retired_cnt"}, retired_cnt, m_cnt);
        check_output({tag, "_illegal"}, illegal, m_illegal);
        if (exp_regwe == 1) check_output({tag, "_reg_we_last"}, regwe_at, exp_cyc);
        if (is_halt) begin
            m_pc = m_pc + 8'd1;
            check_output({tag, "_halt_state"}, state, 3'd6);
        end
        if (drop_run) begin
            check_output({tag, "_idle_after_drop"}, state, 3'd0);
            run = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int halt_strobes;
        int halt_moves;
        logic [3:0]  rop;
        logic [7:0]  pc_at_halt;
        logic [15:0] cnt_at_halt;

        reset      = 1'b1;
        run        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_state", state, 3'd0);
        check_output("rst_pc", pc, 8'h00);
        check_output("rst_ir", ir, 16'h0000);
        check_output("rst_cnt", retired_cnt, 16'h0000);
        check_output("rst_halted", halted, 0);
        check_output("rst_illegal", illegal, 0);
        check_output("rst_strobes", {imem_req, alu_en, dmem_req, dmem_we, reg_we, retire}, 6'b0);

        reset = 1'b0;
        run   = 1'b1;
        apply_stimulus(16'h1023, 0, 0, 0, -1, 0);
        check_output("first_ir", ir, 16'h1023);
        apply_stimulus(16'h0017, 0, 3, 0, -1, 0);
        apply_stimulus(16'h0008, 0, 0, 0, -1, 0);

        apply_stimulus(16'h0FF9, 0, 0, 0, -1, 0);
        apply_stimulus(16'h0AB9, 1, 0, 0, -1, 0);
        check_output("jump_from_ff", pc, 8'hAB);
        apply_stimulus(16'h0FF9, 0, 0, 0, -1, 0);
        apply_stimulus(16'h1023, 2, 0, 0, -1, 0);
        check_output("pc_wrap", pc, 8'h00);

        apply_stimulus(16'h000C, 0, 0, 0, -1, 0);
        apply_stimulus(16'h2041, 0, 0, 0, -1, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 14));
            apply_stimulus({12'($urandom), rop}, $urandom_range(0, 2), $urandom_range(0, 3), 0, -1, 1);
        end

        apply_stimulus(16'h0037, 1, 4, 1, -1, 0);
        apply_stimulus(16'h0005, 0, 0, 0, -1, 0);
        apply_stimulus(16'h0018, 0, 2, 1, -1, 0);

        apply_stimulus(16'h0008, 0, 6, 0, 2, 0);
        #1;
        check_output("abort_state", state, 3'd0);
        check_output("abort_strobes", {imem_req, alu_en, dmem_req, dmem_we, reg_we, retire}, 6'b0);
        check_output("abort_pc", pc, 8'h00);
        @(posedge clk);
        #1;
        check_output("abort_strobes_next", {imem_req, alu_en, dmem_req, dmem_we, reg_we, retire}, 6'b0);
        check_output("abort_cnt", retired_cnt, 16'h0000);
        reset     = 1'b0;
        m_pc      = 8'h00;
        m_cnt     = 16'h0000;
        m_illegal = 1'b0;

        apply_stimulus(16'h1023, 0, 0, 0, -1, 0);
        apply_stimulus(16'h000F, 1, 0, 0, -1, 0);
        check_output("halted_flag", halted, 1);
        pc_at_halt   = pc;
        cnt_at_halt  = retired_cnt;
        halt_strobes = 0;
        halt_moves   = 0;
        for (int i = 0; i < 8; i++) begin
            run = 1'(i % 2);
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            @(posedge clk);
            #1;
            if (imem_req || alu_en || dmem_req || reg_we || retire) halt_strobes++;
            if (state != 3'd6) halt_moves++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check_output("halt_strobes", halt_strobes, 0);
        check_output("halt_state_moves", halt_moves, 0);
        check_output("halt_pc_hold", pc, pc_at_halt);
        check_output("halt_cnt_hold", retired_cnt, cnt_at_halt);

        reset = 1'b1;
        #2;
        check_output("halt_reset_state", state, 3'd0);
        check_output("halt_reset_pc", pc, 8'h00);
        check_output("halt_reset_halted", halted, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
